// File: rtl/libhdl_jk_pkg.sv
// Shared JK-bank definitions: J/K op encodings and sequencer state encodings.
package libhdl_jk_pkg;

    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_CLEAR  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } jk_state_e;

endpackage

// File: rtl/libhdl_jkseq_fifo.sv
// Synchronous command FIFO for the JK sequencer; power-of-two DEPTH, wrapping pointers.
module libhdl_jkseq_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     CK,
    input  logic                     RN,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (fill == FULL_CNT);
    assign empty   = (fill == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage needs no reset; occupancy and pointers define validity.
    always_ff @(posedge CK) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   fill <= fill + (AW+1)'(1);
                2'b01:   fill <= fill - (AW+1)'(1);
                default: fill <= fill;
            endcase
        end
    end

endmodule

// File: rtl/libhdl_jkseqn.sv
// JK command sequencer: queues {op, mask, count} commands and replays each onto J/K
// for count+1 cycles, chaining queued commands without bubbles.
module libhdl_jkseqn
    import libhdl_jk_pkg::*;
#(
    parameter int unsigned N     = 1,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 4
) (
    input  logic                     CK,
    input  logic                     RN,
    input  logic                     IN_VLD,
    output logic                     IN_RDY,
    input  logic [1:0]               IN_OP,
    input  logic [N-1:0]             IN_MASK,
    input  logic [CW-1:0]            IN_CNT,
    output logic [N-1:0]             J,
    output logic [N-1:0]             K,
    output logic                     BUSY,
    output logic [$clog2(DEPTH):0]   FILL
);

    localparam int unsigned W = 2 + N + CW;

    logic [W-1:0]  rdata;
    logic          full;
    logic          empty;
    logic          pop;
    logic [1:0]    f_op;
    logic [N-1:0]  f_mask;
    logic [CW-1:0] f_cnt;

    jk_state_e     state;
    jk_op_e        op;
    logic [N-1:0]  mask;
    logic [CW-1:0] remaining;

    libhdl_jkseq_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CK    (CK),
        .RN    (RN),
        .push  (IN_VLD),
        .pop   (pop),
        .wdata ({IN_OP, IN_MASK, IN_CNT}),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .fill  (FILL)
    );

    assign {f_op, f_mask, f_cnt} = rdata;

    // Pop whenever the execute stage is free or finishing its last cycle.
    assign pop    = !empty && ((state == IDLE) || (remaining == '0));
    assign IN_RDY = !full;
    assign BUSY   = (state == EXEC) || !empty;

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state     <= IDLE;
            op        <= JK_HOLD;
            mask      <= '0;
            remaining <= '0;
        end else if (pop) begin
            state     <= EXEC;
            op        <= jk_op_e'(f_op);
            mask      <= f_mask;
            remaining <= f_cnt;
        end else if (state == EXEC) begin
            if (remaining != '0) begin
                remaining <= remaining - CW'(1);
            end else begin
                state <= IDLE;
                op    <= JK_HOLD;
                mask  <= '0;
            end
        end
    end

    // J/K decode depends only on the execute register.
    always_comb begin
        J = '0;
        K = '0;
        if (state == EXEC) begin
            J = mask & {N{op[1]}};
            K = mask & {N{op[0]}};
        end
    end

endmodule
